systolic_array_ws: RTL

// Parametrised weight-stationary systolic MAC array with built-in control. Loads a ROWSxCOLS

---
 rtl/systolic_array_ws.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_ws.sv
// Weight-stationary systolic MAC array with built-in load/stream control.
// Weights are shifted in row by row from the top; activation vectors are skewed on entry,
// flow right through the PE grid while partial sums flow down, and the bottom-row sums are
// deskewed so every column of one result vector leaves in the same cycle.
module systolic_array_ws #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    input  logic [COLS*DATA_W-1:0] w_data,
    output logic                   w_ready,
    input  logic                   act_valid,
    input  logic [ROWS*DATA_W-1:0] act_data,
    output logic                   act_ready,
    output logic                   out_valid,
    output logic [COLS*ACC_W-1:0]  out_sum,
    output logic                   busy
);

    // Total latency from accept to out_valid; the valid pipe is LAT-1 deep, the
    // output register supplies the last stage.
    localparam int LAT    = ROWS + COLS;
    localparam int CNT_W  = $clog2(LAT + 1);
    localparam int WCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [LAT-2:0]      vld_q, vld_d;
    logic                out_valid_q, out_valid_d;
    logic [COLS*ACC_W-1:0] out_sum_q, out_sum_d;

    logic                w_accept;
    logic                act_accept;

    // Stationary weights, PE activation pipes and PE partial-sum registers
    logic signed [DATA_W-1:0] w_q [ROWS][COLS];
    logic signed [DATA_W-1:0] w_d [ROWS][COLS];
    logic signed [DATA_W-1:0] a_q [ROWS][COLS-1];
    logic signed [DATA_W-1:0] a_d [ROWS][COLS-1];
    logic signed [ACC_W-1:0]  p_q [ROWS][COLS];
    logic signed [ACC_W-1:0]  p_d [ROWS][COLS];

    logic signed [DATA_W-1:0] a_in [ROWS][COLS];
    logic signed [ACC_W-1:0]  p_in [ROWS][COLS];
    logic        [PROD_W-1:0] prod [ROWS][COLS];

    logic [ROWS*DATA_W-1:0] act_in;   // accepted vector, zero on idle cycles
    logic [ROWS*DATA_W-1:0] sk_out;   // skewed activations entering column 0
    logic [COLS*ACC_W-1:0]  ds_out;   // deskewed bottom-row sums, aligned

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register: FSM state and weight-beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state: every accepted beat advances the load; the ROWS-th beat completes it
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (w_accept) begin
            if (wcnt_q == WCNT_W'(ROWS - 1)) begin
                wcnt_d  = '0;
                state_d = StReady;
            end else begin
                wcnt_d  = wcnt_q + WCNT_W'(1);
                state_d = StLoad;
            end
        end
    end

    // Outputs: a reload in READY waits for the array to drain and yields to activations
    always_comb begin
        w_ready   = 1'b1;
        act_ready = 1'b0;
        unique case (state_q)
            StIdle:  w_ready = 1'b1;
            StLoad:  w_ready = 1'b1;
            StReady: begin
                w_ready   = (inflight_q == '0) && !act_valid;
                act_ready = 1'b1;
            end
            default: w_ready = 1'b1;
        endcase
        busy       = (state_q == StLoad) || (inflight_q != '0);
        w_accept   = w_valid && w_ready;
        act_accept = act_valid && act_ready;
    end

    // ------------------------------------------------------------------
    // Valid tracking and output register
    // ------------------------------------------------------------------

    // Next state for the valid pipe, in-flight count and output register
    always_comb begin
        vld_d       = {vld_q[LAT-3:0], act_accept};
        out_valid_d = vld_q[LAT-2];
        out_sum_d   = out_valid_d ? ds_out : out_sum_q;
        inflight_d  = inflight_q;
        if (act_accept && !out_valid_q) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!act_accept && out_valid_q) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Valid pipe, in-flight counter and held output vector
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            inflight_q  <= '0;
        end else begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            inflight_q  <= inflight_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

    // ------------------------------------------------------------------
    // Weight shift register
    // ------------------------------------------------------------------

    // Weights move only on accepted beats: new row enters at the top, rest shift down
    always_comb begin
        w_d = w_q;
        if (w_accept) begin
            for (int c = 0; c < COLS; c++) begin
                w_d[0][c] = w_data[c*DATA_W +: DATA_W];
            end
            for (int r = 1; r < ROWS; r++) begin
                w_d[r] = w_q[r-1];
            end
        end
    end

    // Weight storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            w_q <= w_d;
        end
    end

    // ------------------------------------------------------------------
    // Input skew: row r is delayed r cycles before reaching column 0
    // ------------------------------------------------------------------

    assign act_in                = act_accept ? act_data : '0;
    assign sk_out[DATA_W-1:0]    = act_in[DATA_W-1:0];

    for (genvar r = 1; r < ROWS; r++) begin : g_skew
        logic [DATA_W-1:0] sk_q [r];
        logic [DATA_W-1:0] sk_d [r];

        // Delay line for row r
        always_comb begin
            sk_d[0] = act_in[r*DATA_W +: DATA_W];
            for (int k = 1; k < r; k++) begin
                sk_d[k] = sk_q[k-1];
            end
        end

        // Skew storage for row r
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < r; k++) begin
                    sk_q[k] <= '0;
                end
            end else begin
                sk_q <= sk_d;
            end
        end

        assign sk_out[r*DATA_W +: DATA_W] = sk_q[r-1];
    end

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------

    // PE datapath: activations step right, partial sums step down, each PE adds a*w
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_in[r][0] = sk_out[r*DATA_W +: DATA_W];
            for (int c = 1; c < COLS; c++) begin
                a_in[r][c] = a_q[r][c-1];
            end
        end
        for (int c = 0; c < COLS; c++) begin
            p_in[0][c] = '0;
            for (int r = 1; r < ROWS; r++) begin
                p_in[r][c] = p_q[r-1][c];
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                // Operands sign-extended to product width so the low bits are the signed product
                prod[r][c] = {{DATA_W{a_in[r][c][DATA_W-1]}}, a_in[r][c]}
                           * {{DATA_W{w_q[r][c][DATA_W-1]}}, w_q[r][c]};
                p_d[r][c]  = p_in[r][c]
                           + {{(ACC_W-PROD_W){prod[r][c][PROD_W-1]}}, prod[r][c]};
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS - 1; c++) begin
                a_d[r][c] = a_in[r][c];
            end
        end
    end

    // PE registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    p_q[r][c] <= '0;
                end
                for (int c = 0; c < COLS - 1; c++) begin
                    a_q[r][c] <= '0;
                end
            end
        end else begin
            p_q <= p_d;
            a_q <= a_d;
        end
    end

    // ------------------------------------------------------------------
    // Output deskew: column c waits COLS-1-c cycles so all columns line up
    // ------------------------------------------------------------------

    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int DEPTH = COLS - 1 - c;
        if (DEPTH == 0) begin : g_direct
            assign ds_out[c*ACC_W +: ACC_W] = p_q[ROWS-1][c];
        end else begin : g_chain
            logic [ACC_W-1:0] ds_q [DEPTH];
            logic [ACC_W-1:0] ds_d [DEPTH];

            // Delay line for column c
            always_comb begin
                ds_d[0] = p_q[ROWS-1][c];
                for (int k = 1; k < DEPTH; k++) begin
                    ds_d[k] = ds_q[k-1];
                end
            end

            // Deskew storage for column c
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        ds_q[k] <= '0;
                    end
                end else begin
                    ds_q <= ds_d;
                end
            end

            assign ds_out[c*ACC_W +: ACC_W] = ds_q[DEPTH-1];
        end
    end

endmodule
